// File: rtl/controlador_interrupcao.sv
// rtl/controlador_interrupcao.sv - interrupt controller: halt, one-shot timer and maskable lines with a redirect FSM
// Optional build macro: INT_EDGE_DETECT_EN (external lines latch on rising edges instead of level)
module controlador_interrupcao #(
    parameter int NUM_SRC     = 4,
    parameter int PC_W        = 11,
    parameter int TIMER_W     = 16,
    parameter int VECTOR_ADDR = 0
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               Halt,
    input  logic               set_timer,
    input  logic [TIMER_W-1:0] timer_value,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_data,
    input  logic [PC_W-1:0]    next_pc,
    input  logic               get_interruption,
    output logic               int_take,
    output logic [PC_W-1:0]    vector_pc,
    output logic [PC_W-1:0]    saved_pc,
    output logic [31:0]        cause,
    output logic               int_pending
);

    // Pending bit layout: [0] halt, [1] timer, [2+i] external line i.
    localparam int P_W = NUM_SRC + 2;

    typedef enum logic [1:0] {IDLE, TAKE, SERVICE} state_t;

    state_t             state;
    logic [P_W-1:0]     pend;
    logic [P_W-1:0]     pend_set;
    logic [P_W-1:0]     ack_clr;
    logic [P_W-1:0]     served;
    logic [P_W-1:0]     eligible;
    logic [TIMER_W-1:0] counter;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] irq_hit;
    logic [31:0]        win_code;
    logic               timer_expire;

    // Cause code reported for a given pending bit position.
    function automatic logic [31:0] code_of(input int idx);
        if (idx == 0)
            return 32'd2;
        else if (idx == 1)
            return 32'd1;
        else
            return 32'(idx + 1);
    endfunction

    assign vector_pc = PC_W'(VECTOR_ADDR);

`ifdef INT_EDGE_DETECT_EN
    logic [NUM_SRC-1:0] irq_prev;

    // Previous-sample register for rising-edge detection of external lines.
    always_ff @(posedge Clock) begin
        if (!Reset_n)
            irq_prev <= '0;
        else
            irq_prev <= irq_in;
    end

    assign irq_hit = irq_in & ~irq_prev;
`else
    assign irq_hit = irq_in;
`endif

    // A reload (even a zero stop) in the expiry cycle suppresses the timer event.
    assign timer_expire = (counter == TIMER_W'(1)) && !set_timer;
    assign pend_set     = {irq_hit, timer_expire, Halt};
    assign eligible     = {pend[P_W-1:2] & mask, pend[1:0]};
    assign int_pending  = |eligible;
    assign ack_clr      = (state == SERVICE && get_interruption) ? served : '0;

    // Priority encoder: lowest bit index wins (halt, timer, irq 0, irq 1, ...).
    always_comb begin
        win_code = 32'd0;
        for (int i = P_W - 1; i >= 0; i--) begin
            if (eligible[i])
                win_code = code_of(i);
        end
    end

    // Decode the latched cause back into the pending bit it came from.
    always_comb begin
        served = '0;
        for (int i = 0; i < P_W; i++) begin
            if (cause == code_of(i))
                served[i] = 1'b1;
        end
    end

    // Timer down-counter; zero means stopped.
    always_ff @(posedge Clock) begin
        if (!Reset_n)
            counter <= '0;
        else if (set_timer)
            counter <= timer_value;
        else if (counter != '0)
            counter <= counter - TIMER_W'(1);
    end

    // Pending and mask registers; a new set in the acknowledge cycle wins over the clear.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            pend <= '0;
            mask <= '1;
        end else begin
            pend <= (pend & ~ack_clr) | pend_set;
            if (mask_we)
                mask <= mask_data;
        end
    end

    // Redirect FSM with registered int_take, cause and saved_pc.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state    <= IDLE;
            int_take <= 1'b0;
            cause    <= 32'd0;
            saved_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (int_pending) begin
                        state    <= TAKE;
                        int_take <= 1'b1;
                        cause    <= win_code;
                    end
                end
                TAKE: begin
                    state    <= SERVICE;
                    int_take <= 1'b0;
                    saved_pc <= next_pc;
                end
                SERVICE: begin
                    if (get_interruption) begin
                        state <= IDLE;
                        cause <= 32'd0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    int_take <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_interrupcao.sv
// tb/tb_controlador_interrupcao.sv - randomized self-checking bench for controlador_interrupcao
module tb_controlador_interrupcao;

    localparam int NS = 4;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Halt;
    logic        set_timer;
    logic [15:0] timer_value;
    logic [NS-1:0] irq_in;
    logic        mask_we;
    logic [NS-1:0] mask_data;
    logic [10:0] next_pc;
    logic        get_interruption;
    logic        int_take;
    logic [10:0] vector_pc;
    logic [10:0] saved_pc;
    logic [31:0] cause;
    logic        int_pending;

    int checks   = 0;
    int failures = 0;

    controlador_interrupcao dut (
        .Clock            (Clock),
        .Reset_n          (Reset_n),
        .Halt             (Halt),
        .set_timer        (set_timer),
        .timer_value      (timer_value),
        .irq_in           (irq_in),
        .mask_we          (mask_we),
        .mask_data        (mask_data),
        .next_pc          (next_pc),
        .get_interruption (get_interruption),
        .int_take         (int_take),
        .vector_pc        (vector_pc),
        .saved_pc         (saved_pc),
        .cause            (cause),
        .int_pending      (int_pending)
    );

    always #5 Clock = ~Clock;

    // Reference model: phase 0 waiting, 1 redirecting, 2 in handler.
    bit m_halt_p;
    bit m_tmr_p;
    bit m_irq_p [NS];
    bit m_mask  [NS];
    bit m_prev  [NS];
    int m_cnt;
    int m_phase;
    int m_cause;
    int m_saved;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_winner();
        if (m_halt_p) return 2;
        if (m_tmr_p) return 1;
        for (int i = 0; i < NS; i++)
            if (m_irq_p[i] && m_mask[i]) return 3 + i;
        return 0;
    endfunction

    task automatic model_edge();
        int win;
        int served;
        bit rise;
        if (!Reset_n) begin
            m_halt_p = 0; m_tmr_p = 0; m_cnt = 0; m_phase = 0; m_cause = 0; m_saved = 0;
            for (int i = 0; i < NS; i++) begin
                m_irq_p[i] = 0; m_mask[i] = 1; m_prev[i] = 0;
            end
            return;
        end
        win    = m_winner();
        served = (m_phase == 2 && get_interruption) ? m_cause : 0;
        case (m_phase)
            0: if (win != 0) begin m_phase = 1; m_cause = win; end
            1: begin m_phase = 2; m_saved = int'(next_pc); end
            default: if (get_interruption) begin m_phase = 0; m_cause = 0; end
        endcase
        if (served == 2) m_halt_p = 0;
        if (served == 1) m_tmr_p = 0;
        if (served >= 3) m_irq_p[served - 3] = 0;
        if (Halt) m_halt_p = 1;
        if (!set_timer && m_cnt == 1) m_tmr_p = 1;
        m_cnt = set_timer ? int'(timer_value) : (m_cnt > 0 ? m_cnt - 1 : 0);
        for (int i = 0; i < NS; i++) begin
`ifdef INT_EDGE_DETECT_EN
            rise = irq_in[i] && !m_prev[i];
`else
            rise = irq_in[i];
`endif
            if (rise) m_irq_p[i] = 1;
            m_prev[i] = irq_in[i];
            if (mask_we) m_mask[i] = mask_data[i];
        end
    endtask

    task automatic compare_all();
        check("int_take", 32'(int_take), 32'(m_phase == 1));
        check("cause", cause, 32'(m_cause));
        check("saved_pc", 32'(saved_pc), 32'(m_saved));
        check("int_pending", 32'(int_pending), 32'(m_winner() != 0));
        check("vector_pc", 32'(vector_pc), 32'd0);
    endtask

    task automatic drive(input bit rst, input bit h, input bit st, input int tv,
                         input logic [NS-1:0] irq, input bit mwe, input logic [NS-1:0] md,
                         input int npc, input bit ack);
        Reset_n = rst; Halt = h; set_timer = st; timer_value = 16'(tv);
        irq_in = irq; mask_we = mwe; mask_data = md; next_pc = 11'(npc);
        get_interruption = ack;
        model_edge();
        @(posedge Clock);
        @(negedge Clock);
        compare_all();
    endtask

    task automatic idle_step(input logic [NS-1:0] irq, input bit ack);
        drive(1, 0, 0, 0, irq, 0, 4'h0, 0, ack);
    endtask

    initial begin
        // Reset state.
        drive(0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 0);
        drive(0, 1, 1, 5, 4'hF, 0, 4'h0, 9, 1);
        check("rst_int_take", 32'(int_take), 32'd0);
        check("rst_cause", cause, 32'd0);
        check("rst_saved_pc", 32'(saved_pc), 32'd0);
        check("rst_pending", 32'(int_pending), 32'd0);

        // Timer of 3 expires at edge 3, redirect after edge 4.
        drive(1, 0, 1, 3, 4'h0, 0, 4'h0, 0, 0);
        idle_step(4'h0, 0);
        idle_step(4'h0, 0);
        check("tmr_not_yet", 32'(int_pending), 32'd0);
        idle_step(4'h0, 0);
        check("tmr_pending", 32'(int_pending), 32'd1);
        check("tmr_no_take", 32'(int_take), 32'd0);
        idle_step(4'h0, 0);
        check("tmr_take", 32'(int_take), 32'd1);
        check("tmr_cause", cause, 32'd1);
        idle_step(4'h0, 1);
        idle_step(4'h0, 1);
        check("tmr_acked", cause, 32'd0);

        // Halt and line 0 together: halt first, then line 0.
        drive(1, 1, 0, 0, 4'h1, 0, 4'h0, 0, 0);
        idle_step(4'h0, 0);
        check("sim_cause_halt", cause, 32'd2);
        idle_step(4'h0, 0);
        idle_step(4'h0, 1);
        check("sim_ack_cause", cause, 32'd0);
        check("sim_still_pend", 32'(int_pending), 32'd1);
        idle_step(4'h0, 0);
        check("sim_take2", 32'(int_take), 32'd1);
        check("sim_cause_irq0", cause, 32'd3);
        idle_step(4'h0, 0);
        idle_step(4'h0, 1);

        // Masked line 1 stays latched until enabled; return address capture.
        drive(1, 0, 0, 0, 4'h0, 1, 4'b1101, 0, 0);
        idle_step(4'b0010, 0);
        idle_step(4'h0, 0);
        check("mask_blocked", 32'(int_pending), 32'd0);
        check("mask_no_take", 32'(int_take), 32'd0);
        drive(1, 0, 0, 0, 4'h0, 1, 4'b1111, 0, 0);
        check("mask_enabled", 32'(int_pending), 32'd1);
        idle_step(4'h0, 0);
        check("mask_cause", cause, 32'd4);
        drive(1, 0, 0, 0, 4'h0, 0, 4'h0, 37, 0);
        check("ret_saved_pc", 32'(saved_pc), 32'd37);
        check("ret_vector", 32'(vector_pc), 32'd0);
        idle_step(4'h0, 1);
        check("ret_cause0", cause, 32'd0);
        check("ret_saved_hold", 32'(saved_pc), 32'd37);

        // Line 0 held high across acknowledge.
        idle_step(4'h1, 0);
        idle_step(4'h1, 0);
        check("lvl_take", 32'(int_take), 32'd1);
        idle_step(4'h1, 0);
        idle_step(4'h1, 1);
        idle_step(4'h1, 0);
`ifdef INT_EDGE_DETECT_EN
        check("lvl_retake", 32'(int_take), 32'd0);
`else
        check("lvl_retake", 32'(int_take), 32'd1);
`endif
        for (int i = 0; i < 3; i++) idle_step(4'h0, 1);

        // Reset while redirecting.
        idle_step(4'h1, 0);
        idle_step(4'h0, 0);
        check("rt_in_take", 32'(int_take), 32'd1);
        drive(0, 0, 0, 0, 4'h0, 0, 4'h0, 0, 1);
        check("rt_int_take", 32'(int_take), 32'd0);
        check("rt_cause", cause, 32'd0);
        check("rt_pend", 32'(int_pending), 32'd0);
        idle_step(4'b0010, 0);
        check("rt_mask_ones", 32'(int_pending), 32'd1);
        idle_step(4'h0, 0);
        check("rt_cause_irq1", cause, 32'd4);
        idle_step(4'h0, 0);
        idle_step(4'h0, 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 11) == 0),
                  int'($urandom_range(0, 6)),
                  4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                  ($urandom_range(0, 15) == 0),
                  4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 2047)),
                  ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controlador_interrupcao.md
CONTROLADOR_INTERRUPCAO -- requirements
Module: controlador_interrupcao

Interface
REQ-001 Parameter NUM_SRC, default 4: number of external interrupt lines, range 1..16.
REQ-002 Parameter PC_W, default 11: program-counter width.
REQ-003 Parameter TIMER_W, default 16: timer reload width.
REQ-004 Parameter VECTOR_ADDR, default 0: handler address driven on redirect.
REQ-005 One clock; reset is synchronous and active-low; ports named Clock and Reset_n.
REQ-006 Clock  in  1  CPU clock; all state updates on rising edge.
REQ-007 Reset_n  in  1  synchronous active-low reset.
REQ-008 Halt  in  1  halt request from control unit; highest-priority source.
REQ-009 set_timer  in  1  load timer from timer_value.
REQ-010 timer_value  in  TIMER_W  timer reload (instruction immediate); 0 disables the timer.
REQ-011 irq_in  in  NUM_SRC  external interrupt lines.
REQ-012 mask_we  in  1  write mask register.
REQ-013 mask_data  in  NUM_SRC  mask value; 1 = enabled.
REQ-014 next_pc  in  PC_W  PC value the CPU would load this cycle.
REQ-015 get_interruption  in  1  handler acknowledge; clears the served source.
REQ-016 int_take  out  1  one-cycle redirect pulse; CPU loads vector_pc instead of next_pc.
REQ-017 vector_pc  out  PC_W  constant VECTOR_ADDR.
REQ-018 saved_pc  out  PC_W  return address of the interrupted flow.
REQ-019 cause  out  32  0 none, 1 timer, 2 halt, 3+i external line i.
REQ-020 int_pending  out  1  any eligible pending source.

Function
REQ-021 Pending register pend holds bits for halt, timer, and irq 0..NUM_SRC-1; set on sample, cleared only by acknowledge or reset.
REQ-022 Halt high at a rising edge shall set pend[halt].
REQ-023 set_timer with nonzero timer_value shall load the counter; set_timer with 0 shall stop it and leave pend[timer] unchanged.
REQ-024 A nonzero counter shall decrement by 1 per cycle; the 1->0 transition shall set pend[timer].
REQ-025 set_timer in the expiry cycle: reload wins, pend[timer] not set.
REQ-026 Halt and timer are unmaskable; an external line is eligible only when pending and its mask bit is 1; masked lines still latch pending.
REQ-027 Priority: halt > timer > irq 0 > irq 1 > ... > irq NUM_SRC-1.
REQ-028 FSM states IDLE, TAKE, SERVICE.
REQ-029 IDLE -> TAKE at the edge where int_pending is 1; cause latched with the winner's code at the same edge.
REQ-030 In TAKE int_take is 1 for exactly one cycle; at the leaving edge saved_pc <= next_pc, state -> SERVICE.
REQ-031 Event-to-int_take latency: 2 cycles (sample edge, then TAKE-entry edge).
REQ-032 SERVICE: no new take (no nesting); sources keep latching pending.
REQ-033 get_interruption in SERVICE: clear the served pend bit, cause <= 0, state -> IDLE; saved_pc held.
REQ-034 get_interruption in IDLE or TAKE is ignored.
REQ-035 Served source re-asserting in the acknowledge cycle: set wins, bit stays pending.
REQ-036 mask_we takes effect at the next edge; a mask change never aborts TAKE or SERVICE.

Reset
REQ-037 Reset_n low at an edge: state IDLE, pend 0, counter 0, mask all-ones, cause 0, saved_pc 0, int_take 0; overrides every other input including mid-TAKE.

Configuration
REQ-038 Macro INT_EDGE_DETECT_EN defined: external pend bit set only on a rising edge of irq_in, using registered previous-sample bits cleared on reset.
REQ-039 INT_EDGE_DETECT_EN undefined: external pend bit set whenever irq_in is high (level), so a line still high after acknowledge re-pends; halt and timer identical in both builds.

Verification
REQ-040 Timer: set_timer, timer_value=3 at edge 0 -> pend[timer] at edge 3, int_take high cycle after edge 4, cause=1.
REQ-041 Simultaneous: Halt and irq_in=4'b0001 at same edge -> cause=2; after ack, second take with cause=3.
REQ-042 Mask: mask_data=4'b1101, irq_in[1] pulsed -> int_pending=0; mask_data=4'b1111 -> take with cause=4.
REQ-043 Return: next_pc=11'd37 during TAKE -> saved_pc=37, vector_pc=0; ack -> cause=0, state IDLE.
REQ-044 Level vs edge: irq_in[0] held high across ack -> retaken with macro undefined, not retaken with INT_EDGE_DETECT_EN.
REQ-045 Reset in TAKE: Reset_n low -> int_take 0 next cycle, cause 0, pend 0, mask 4'b1111.
